// File: rtl/i2c_master_burst.sv
// ---------------------------------------------------------------------------
// i2c_master_burst
//   I2C master running multi-byte write or read bursts to one 7-bit address.
//   SCL is derived from the system clock. Each bit is four quarters of DIV
//   clocks (Q0 SCL low / SDA update, Q1-Q2 SCL high with the sample at Q2
//   entry, Q3 SCL low). The slave ACK/NACK is sampled on open-drain SDA and
//   bytes go MSB first.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start/rw/addr/nbytes  burst request; accepted only while idle
//   wdata/wr_valid/wr_ready  write byte stream; wr_ready marks the consuming cycle
//   rdata/rd_valid      read byte stream, one rd_valid pulse per byte
//   busy/done/ack_err   status; done pulses when STOP completes,
//                       ack_err reports a slave NACK until the next start
//   scl                 push-pull SCL
//   sda                 open-drain SDA (drives 0 or releases)
// ---------------------------------------------------------------------------
module i2c_master_burst #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCL_FREQ = 400_000,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] nbytes,
  input  logic [7:0]       wdata,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rdata,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl,
  inout  wire              sda
);

  localparam int DIV   = CLK_FREQ / (4 * SCL_FREQ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       q_q, q_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             nack_q, nack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             sda_s1_q, sda_s2_q;
  logic             wr_ready_c;
  logic             tick;

  // SCL level for a given phase and quarter.
  function automatic logic scl_level(input state_e s, input logic [1:0] q);
    case (s)
      S_IDLE:  scl_level = 1'b1;
      S_START: scl_level = (q != 2'd3);
      default: scl_level = (q == 2'd1) || (q == 2'd2);
    endcase
  endfunction

  // SDA pull-down enable for a given phase and quarter.
  function automatic logic sda_pull(input state_e s, input logic [1:0] q,
                                    input logic tx_bit, input logic more);
    case (s)
      S_START:         sda_pull = (q >= 2'd2);
      S_ADDR, S_WDATA: sda_pull = ~tx_bit;
      S_RACK:          sda_pull = more;        // ACK unless this was the last byte
      S_STOP:          sda_pull = (q < 2'd2);  // release at Q2 makes the STOP edge
      default:         sda_pull = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    bit_d      = bit_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    nack_d     = nack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    rd_valid_d = 1'b0;
    rdata_d    = rdata_q;
    wr_ready_c = 1'b0;

    tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

    if (state_q == S_IDLE || tick) div_d = '0;
    else                           div_d = div_q + DIV_W'(1);

    // Quarter wraps 3 -> 0 on its own; phase changes happen at Q3 ticks.
    if (tick) q_d = q_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START;
          q_d       = 2'd0;
          rw_d      = rw;
          tx_d      = {addr, rw};
          cnt_d     = nbytes;
          nack_d    = 1'b0;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
        end
      end
      S_START: begin
        if (tick && q_q == 2'd3) begin
          state_d = S_ADDR;
          bit_d   = 3'd7;
        end
      end
      S_ADDR, S_WDATA: begin
        if (tick && q_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_AACK, S_WACK: begin
        if (tick && q_q == 2'd1) nack_d = sda_s2_q;
        if (tick && q_q == 2'd3) begin
          if (nack_q || cnt_q == '0) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RDATA;
            bit_d   = 3'd7;
          end else if (wr_valid) begin
            wr_ready_c = 1'b1;
            tx_d       = wdata;
            cnt_d      = cnt_q - LEN_W'(1);
            state_d    = S_WDATA;
            bit_d      = 3'd7;
          end else begin
            // No byte yet: hold Q3 (SCL low, SDA untouched) and retry every clock.
            q_d   = q_q;
            div_d = div_q;
          end
        end
      end
      S_RDATA: begin
        if (tick && q_q == 2'd1) rx_d = {rx_q[6:0], sda_s2_q};
        if (tick && q_q == 2'd2 && bit_q == 3'd0) begin
          rd_valid_d = 1'b1;
          rdata_d    = rx_q;
          cnt_d      = cnt_q - LEN_W'(1);
        end
        if (tick && q_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_RACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_RACK: begin
        if (tick && q_q == 2'd3) begin
          if (cnt_q == '0) begin
            state_d = S_STOP;
          end else begin
            state_d = S_RDATA;
            bit_d   = 3'd7;
          end
        end
      end
      S_STOP: begin
        if (tick && q_q == 2'd2) begin
          state_d   = S_IDLE;
          q_d       = 2'd0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          ack_err_d = nack_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins follow the next phase so they change exactly on quarter entry.
    scl_d    = scl_level(state_d, q_d);
    sda_oe_d = sda_pull(state_d, q_d, tx_d[bit_d], cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      q_q        <= 2'd0;
      bit_q      <= 3'd0;
      div_q      <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= 8'h00;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      rd_valid_q <= rd_valid_d;
      rdata_q    <= rdata_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      // SDA is asynchronous to clk; two flops before it is used.
      sda_s1_q   <= sda;
      sda_s2_q   <= sda_s1_q;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign scl      = scl_q;
  assign wr_ready = wr_ready_c;
  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
module tb_i2c_master_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [6:0] addr;
  logic [3:0] nbytes;
  logic [7:0] wdata;
  logic       wr_valid, wr_ready;
  logic [7:0] rdata;
  logic       rd_valid, busy, done, ack_err, scl;
  wire        sda;

  pullup (sda);

  i2c_master_burst #(.CLK_FREQ(8), .SCL_FREQ(1), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .nbytes(nbytes),
    .wdata(wdata), .wr_valid(wr_valid), .wr_ready(wr_ready), .rdata(rdata),
    .rd_valid(rd_valid), .busy(busy), .done(done), .ack_err(ack_err),
    .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int stops  = 0;
  int wr_cnt = 0;

  logic [7:0] exp_wire[$];
  logic [7:0] exp_rd[$];
  logic       exp_done[$];
  logic       exp_mack[$];
  logic [7:0] wq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic       slv_oe = 1'b0;
  logic [6:0] slv_addr = 7'h50;
  int         nack_idx = 0;
  logic [7:0] slv_tx[$];
  int         bcnt = 0;
  int         dcount = 0;
  bit         rcv = 1, first = 1, after_ack = 0, active = 0;
  bit         addressed = 0, rd_mode = 0, nacked = 0, mack = 0, load_tx = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] txb = 8'hFF;

  assign sda = slv_oe ? 1'b0 : 1'bz;

  always @(negedge sda) if (scl === 1'b1) begin
    starts++;
    bcnt = 0; dcount = 0; rcv = 1; first = 1; after_ack = 0; active = 1;
    nacked = 0; slv_oe = 0;
  end

  always @(posedge sda) if (scl === 1'b1) begin
    stops++;
    active = 0; slv_oe = 0;
  end

  always @(posedge scl) if (active) begin
    if (bcnt < 8) begin
      if (rcv) sh = {sh[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
      bcnt++;
    end else begin
      if (!rcv) begin
        mack = (sda === 1'b0);
        if (exp_mack.size() == 0) chk("master_ack_unexpected", 1, 0);
        else chk("master_ack", int'(mack), int'(exp_mack.pop_front()));
      end
      bcnt = 0;
      after_ack = 1;
    end
  end

  always @(negedge scl) if (active) begin
    if (bcnt == 8) begin
      if (rcv) begin
        if (exp_wire.size() == 0) chk("wire_byte_unexpected", int'(sh), 256);
        else chk("wire_byte", int'(sh), int'(exp_wire.pop_front()));
        if (first) begin
          addressed = (sh[7:1] == slv_addr);
          rd_mode   = sh[0];
          nacked    = !addressed;
        end else begin
          dcount++;
          nacked = (dcount == nack_idx);
        end
        slv_oe = !nacked;
      end else begin
        slv_oe = 0;
      end
    end else if (bcnt == 0 && after_ack) begin
      after_ack = 0; slv_oe = 0; load_tx = 0;
      if (rcv && nacked) active = 0;
      else if (first) begin
        first = 0;
        if (rd_mode) begin rcv = 0; load_tx = 1; end
      end else if (!rcv) begin
        if (mack) load_tx = 1; else active = 0;
      end
      if (active && load_tx) begin
        txb = (slv_tx.size() != 0) ? slv_tx.pop_front() : 8'hFF;
        slv_oe = !txb[7];
      end
    end else if (bcnt >= 1 && bcnt <= 7 && !rcv) begin
      slv_oe = !txb[7 - bcnt];
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_rd.size() == 0) chk("rdata_unexpected", int'(rdata), 256);
      else chk("rdata", int'(rdata), int'(exp_rd.pop_front()));
    end
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else chk("ack_err_at_done", int'(ack_err), int'(exp_done.pop_front()));
    end
  end

  // ---------------- write byte feeder ----------------
  initial begin
    wr_valid = 1'b0;
    wdata    = 8'h00;
    forever begin
      @(negedge clk);
      wr_valid = (wq.size() != 0);
      wdata    = (wq.size() != 0) ? wq[0] : 8'h00;
      #1;
      if (wr_valid && wr_ready) begin
        @(posedge clk);
        #1;
        if (wq.size() != 0) void'(wq.pop_front());
        wr_cnt++;
        wr_valid = (wq.size() != 0);
        wdata    = (wq.size() != 0) ? wq[0] : 8'h00;
      end
    end
  end

  task automatic issue(input logic r, input logic [6:0] a, input logic [3:0] n);
    @(negedge clk);
    rw = r; addr = a; nbytes = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  int s0, p0, w0, low, k;
  bit bad;
  logic sda_ref;

  initial begin
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; nbytes = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda === 1'b1), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rdata", int'(rdata), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write 0x50, two bytes, plus an ignored start while busy
    slv_addr = 7'h50; nack_idx = 0;
    exp_wire.push_back(8'hA0); exp_wire.push_back(8'hA5); exp_wire.push_back(8'h3C);
    exp_done.push_back(1'b0);
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    s0 = starts; p0 = stops; w0 = wr_cnt;
    issue(1'b0, 7'h50, 4'd2);
    chk("t1_busy", int'(busy), 1);
    repeat (30) @(negedge clk);
    issue(1'b1, 7'h33, 4'd5);
    wait_done("t1");
    chk("t1_wr_ready_cnt", wr_cnt - w0, 2);
    chk("t1_starts", starts - s0, 1);
    chk("t1_stops", stops - p0, 1);
    chk("t1_busy_after", int'(busy), 0);

    // 2: read 0x68, three bytes
    slv_addr = 7'h68;
    slv_tx.push_back(8'h11); slv_tx.push_back(8'h22); slv_tx.push_back(8'h33);
    exp_wire.push_back(8'hD1);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_mack.push_back(1'b1); exp_mack.push_back(1'b1); exp_mack.push_back(1'b0);
    exp_done.push_back(1'b0);
    s0 = starts; p0 = stops;
    issue(1'b1, 7'h68, 4'd3);
    wait_done("t2");
    chk("t2_starts", starts - s0, 1);
    chk("t2_stops", stops - p0, 1);

    // 3: address NACK
    slv_addr = 7'h50;
    exp_wire.push_back(8'h24);
    exp_done.push_back(1'b1);
    wq.push_back(8'h77);
    p0 = stops; w0 = wr_cnt;
    issue(1'b0, 7'h12, 4'd1);
    wait_done("t3");
    chk("t3_wr_ready_cnt", wr_cnt - w0, 0);
    chk("t3_stops", stops - p0, 1);
    chk("t3_ack_err_held", int'(ack_err), 1);
    wq.delete();
    repeat (4) @(negedge clk);

    // address probe, nbytes=0; ack_err must clear on the new start
    exp_wire.push_back(8'hA0);
    exp_done.push_back(1'b0);
    w0 = wr_cnt;
    issue(1'b0, 7'h50, 4'd0);
    chk("probe_ack_err_cleared", int'(ack_err), 0);
    wait_done("probe");
    chk("probe_wr_ready_cnt", wr_cnt - w0, 0);

    // 4: write three bytes, slave NACKs the second
    nack_idx = 2;
    exp_wire.push_back(8'hA0); exp_wire.push_back(8'h01); exp_wire.push_back(8'h02);
    exp_done.push_back(1'b1);
    wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03);
    p0 = stops; w0 = wr_cnt;
    issue(1'b0, 7'h50, 4'd3);
    wait_done("t4");
    chk("t4_wr_ready_cnt", wr_cnt - w0, 2);
    chk("t4_stops", stops - p0, 1);
    chk("t4_byte3_left", wq.size(), 1);
    wq.delete();
    nack_idx = 0;
    repeat (4) @(negedge clk);

    // 5: clock stretch before byte 2
    exp_wire.push_back(8'hA0); exp_wire.push_back(8'h5A); exp_wire.push_back(8'hC3);
    exp_done.push_back(1'b0);
    wq.push_back(8'h5A);
    w0 = wr_cnt;
    issue(1'b0, 7'h50, 4'd2);
    k = 0;
    while (wr_cnt == w0 && k < 500) begin @(negedge clk); k++; end
    chk("t5_byte1_taken", wr_cnt - w0, 1);
    low = 0; k = 0;
    while (low < 6 && k < 400) begin
      @(negedge clk);
      low = (scl == 1'b0) ? low + 1 : 0;
      k++;
    end
    chk("t5_stretch_seen", int'(low >= 6), 1);
    sda_ref = sda; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (scl !== 1'b0 || sda !== sda_ref) bad = 1;
    end
    chk("t5_stretch_hold", int'(bad), 0);
    wq.push_back(8'hC3);
    wait_done("t5");
    chk("t5_wr_ready_cnt", wr_cnt - w0, 2);

    // 6: reset in the middle of a read
    slv_addr = 7'h68;
    slv_tx.delete(); slv_tx.push_back(8'hFF); slv_tx.push_back(8'hFF);
    exp_wire.push_back(8'hD1);
    p0 = stops;
    issue(1'b1, 7'h68, 4'd2);
    repeat (100) @(negedge clk);
    chk("t6_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_scl", int'(scl), 1);
    chk("t6_rst_sda", int'(sda === 1'b1), 1);
    chk("t6_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_stop", stops - p0, 0);
    chk("t6_idle_busy", int'(busy), 0);

    chk("left_wire", exp_wire.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_done", exp_done.size(), 0);
    chk("left_mack", exp_mack.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
